// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants for the BT.601 full-range YCbCr -> RGB conversion.
// Coefficients are Q8 (value * 256), ACC_W is the signed accumulator width.
// Also used by the forward converter's reference model.
package ycbcr2rgb_pkg;
  localparam int C_R_CR     = 359;  // 1.402 * 256
  localparam int C_G_CB     = 88;   // 0.344 * 256
  localparam int C_G_CR     = 183;  // 0.714 * 256
  localparam int C_B_CB     = 454;  // 1.772 * 256
  localparam int CHROMA_OFS = 128;
  localparam int ROUND      = 128;  // half an LSB after the >>> FRAC
  localparam int FRAC       = 8;
  localparam int ACC_W      = 20;
endpackage

// File: rtl/sat_u8.sv
// Q8 signed accumulator to 8-bit unsigned pixel: floor(s / 2^FRAC) clamped to 0..255.
// Latency: combinational.
// Backpressure: none (no state).
// Ports: s - signed ACC_W accumulator; u - saturated 8-bit result.
module sat_u8 #(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] s,
  output logic        [7:0]       u
);
  import ycbcr2rgb_pkg::*;

  // Fraction bits are discarded by the floor; only the integer part matters.
  logic unused_frac;
  assign unused_frac = ^s[FRAC-1:0];

  always_comb begin
    if (s[ACC_W-1])
      u = 8'h00;                       // negative -> low clamp
    else if (|s[ACC_W-2:FRAC+8])
      u = 8'hFF;                       // integer part above 255 -> high clamp
    else
      u = s[FRAC+7:FRAC];
  end
endmodule

// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr 4:4:4 -> 8-bit RGB, 3-stage Q8 pipeline with sideband tag.
// Latency: 3 enabled cycles; throughput 1 pixel/clk.
// Backpressure: global stall, en = ~out_valid | out_ready; in_ready = en (comb from out_ready).
// Ports: clk/rst (sync, active-high); in_valid/in_ready/y_in/cb_in/cr_in/user_in;
//        out_valid/out_ready/r_out/g_out/b_out/user_out.
module ycbcr2rgb #(
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        y_in,
  input  logic [7:0]        cb_in,
  input  logic [7:0]        cr_in,
  input  logic [USER_W-1:0] user_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic [USER_W-1:0] user_out
);
  import ycbcr2rgb_pkg::*;

  localparam logic signed [ACC_W-1:0] K_R_CR = ACC_W'(C_R_CR);
  localparam logic signed [ACC_W-1:0] K_G_CB = ACC_W'(C_G_CB);
  localparam logic signed [ACC_W-1:0] K_G_CR = ACC_W'(C_G_CR);
  localparam logic signed [ACC_W-1:0] K_B_CB = ACC_W'(C_B_CB);

  logic en;
  logic s1_vld, s2_vld;

  // S1 state
  logic signed [8:0]       cbs1, crs1;
  logic signed [ACC_W-1:0] ys1;
  logic [USER_W-1:0]       user1;
  // S2 state
  logic signed [ACC_W-1:0] ys2, pr2, pgb2, pgr2, pb2;
  logic [USER_W-1:0]       user2;
  // S3 combinational sums and clamped results
  logic signed [ACC_W-1:0] sr, sg, sb;
  logic [7:0]              r_sat, g_sat, b_sat;
  logic signed [ACC_W-1:0] cbs1_x, crs1_x;

  // The whole pipe moves together; bubbles are carried, never squeezed out.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign cbs1_x = {{(ACC_W-9){cbs1[8]}}, cbs1};
  assign crs1_x = {{(ACC_W-9){crs1[8]}}, crs1};

  // Worst case |sum| < 2^18, so the 20-bit sums never wrap.
  assign sr = ys2 + pr2;
  assign sg = ys2 - pgb2 - pgr2;
  assign sb = ys2 + pb2;

  sat_u8 #(.ACC_W(ACC_W)) u_sat_r (.s(sr), .u(r_sat));
  sat_u8 #(.ACC_W(ACC_W)) u_sat_g (.s(sg), .u(g_sat));
  sat_u8 #(.ACC_W(ACC_W)) u_sat_b (.s(sb), .u(b_sat));

  // Control and output registers: cleared by reset, advanced only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      user_out  <= '0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      r_out     <= r_sat;
      g_out     <= g_sat;
      b_out     <= b_sat;
      user_out  <= user2;
    end
  end

  // Datapath registers: contents behind a cleared valid are don't-care.
  always_ff @(posedge clk) begin
    if (en) begin
      // S1: remove chroma offset, put luma in Q8 with the rounding half-LSB.
      cbs1  <= $signed({1'b0, cb_in} - 9'(CHROMA_OFS));
      crs1  <= $signed({1'b0, cr_in} - 9'(CHROMA_OFS));
      ys1   <= $signed({{(ACC_W-16){1'b0}}, y_in, 8'(ROUND)});
      user1 <= user_in;
      // S2: the four chroma products.
      ys2   <= ys1;
      pr2   <= crs1_x * K_R_CR;
      pgb2  <= cbs1_x * K_G_CB;
      pgr2  <= crs1_x * K_G_CR;
      pb2   <= cbs1_x * K_B_CB;
      user2 <= user1;
    end
  end
endmodule

// File: tb/tb_ycbcr2rgb.sv
module tb_ycbcr2rgb;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y_in, cb_in, cr_in;
  logic [0:0] user_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r_out, g_out, b_out;
  logic [0:0] user_out;

  int checks = 0;
  int errors = 0;
  logic [24:0] expq[$];   // expected {r,g,b,user} in acceptance order

  ycbcr2rgb #(.USER_W(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in), .user_in(user_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .user_out(user_out)
  );

  always #5 clk = ~clk;

  // Reference: R = Y + 1.402 Cr', G = Y - 0.344 Cb' - 0.714 Cr', B = Y + 1.772 Cb'
  // in Q8, rounded half-up, clamped to 0..255.
  function automatic logic [7:0] clamp8(input int s);
    int q;
    q = s >>> 8;
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return q[7:0];
  endfunction

  function automatic logic [24:0] model(input logic [23:0] pix, input logic u);
    int y, cb, cr, base;
    y    = int'(pix[23:16]);
    cb   = int'(pix[15:8]) - 128;
    cr   = int'(pix[7:0]) - 128;
    base = y * 256 + 128;
    return {clamp8(base + 359 * cr), clamp8(base - 88 * cb - 183 * cr),
            clamp8(base + 454 * cb), u};
  endfunction

  // Drive one cycle, observe just before the edge, then advance past the edge.
  task automatic step(input logic iv, input logic [23:0] pix, input logic u, input logic ordy,
                      output logic acc, output logic ov, output logic ir,
                      output logic drained, output logic [24:0] obs);
    in_valid  = iv;
    {y_in, cb_in, cr_in} = pix;
    user_in   = u;
    out_ready = ordy;
    #1;
    acc     = in_valid && in_ready;
    ov      = out_valid;
    ir      = in_ready;
    drained = out_valid && out_ready;
    obs     = {r_out, g_out, b_out, user_out};
    if (acc && !rst) expq.push_back(model(pix, u));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y_in = '0; cb_in = '0; cr_in = '0; user_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if ({r_out, g_out, b_out, user_out} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {r_out, g_out, b_out, user_out});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [23:0] pix [4];
    logic [23:0] want [4];
    logic acc, ov, ir, d;
    logic [24:0] obs, e;
    int lat;
    pix[0] = {8'd128, 8'd128, 8'd128}; want[0] = {8'd128, 8'd128, 8'd128}; // gray
    pix[1] = {8'd76,  8'd85,  8'd255}; want[1] = {8'd254, 8'd0,   8'd0};   // red
    pix[2] = {8'd255, 8'd128, 8'd255}; want[2] = {8'd255, 8'd164, 8'd255}; // R raw 433
    pix[3] = {8'd0,   8'd0,   8'd128}; want[3] = {8'd0,   8'd44,  8'd0};   // B clamps low
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pix[i], i[0], 1'b1, acc, ov, ir, d, obs);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        step(1'b0, 24'd0, 1'b0, 1'b1, acc, ov, ir, d, obs);
        if (d) begin lat = k; break; end
      end
      checks++;
      if (lat != 3) begin
        errors++; $display("FAIL directed_latency[%0d] got %0d want 3", i, lat);
      end
      e = (expq.size() > 0) ? expq.pop_front() : 25'h0;
      checks++;
      if (obs !== {want[i], i[0]} || obs !== e) begin
        errors++; $display("FAIL directed_pixel[%0d] got %h want %h", i, obs, {want[i], i[0]});
      end
    end
  endtask

  task automatic test_throughput();
    logic acc, ov, ir, d;
    logic [24:0] obs, e;
    int first, ndrain;
    first = -1; ndrain = 0;
    for (int k = 0; k < 24; k++) begin
      step(k < 20, 24'($urandom), 1'($urandom), 1'b1, acc, ov, ir, d, obs);
      if (d) begin
        if (first < 0) first = k;
        ndrain++;
        e = (expq.size() > 0) ? expq.pop_front() : 25'h0;
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL thru_data step %0d got %h want %h", k, obs, e);
        end
      end
    end
    checks++;
    if (first != 3) begin
      errors++; $display("FAIL thru_first got %0d want 3", first);
    end
    checks++;
    if (ndrain != 20) begin
      errors++; $display("FAIL thru_count got %0d want 20", ndrain);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] pix [10];
    logic acc, ov, ir, d, ordy, prev_stall;
    logic [24:0] obs, e, prev_obs;
    int sent, got, budget;
    for (int i = 0; i < 10; i++) pix[i] = 24'($urandom);
    sent = 0; got = 0; budget = 0; prev_stall = 1'b0; prev_obs = '0;
    while ((sent < 10 || got < 10) && budget < 300) begin
      budget++;
      ordy = 1'($urandom_range(0, 1));
      step(sent < 10, (sent < 10) ? pix[sent] : 24'd0, 1'(sent), ordy, acc, ov, ir, d, obs);
      checks++;
      if (ir !== (!ov || ordy)) begin
        errors++; $display("FAIL bp_in_ready got %b want %b", ir, (!ov || ordy));
      end
      if (prev_stall) begin
        checks++;
        if (!ov || obs !== prev_obs) begin
          errors++; $display("FAIL bp_stable got v=%b %h want v=1 %h", ov, obs, prev_obs);
        end
      end
      if (acc) sent++;
      if (d) begin
        got++;
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra got %h want nothing", obs);
        end else begin
          e = expq.pop_front();
          if (obs !== e) begin
            errors++; $display("FAIL bp_data #%0d got %h want %h", got, obs, e);
          end
        end
      end
      prev_stall = ov && !ordy;
      prev_obs   = obs;
    end
    checks++;
    if (got != 10 || expq.size() != 0) begin
      errors++; $display("FAIL bp_complete got %0d drained (%0d pending) want 10", got, expq.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic acc, ov, ir, d;
    logic [24:0] obs, e;
    logic [23:0] p;
    int lat;
    for (int i = 0; i < 3; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0, acc, ov, ir, d, obs);
    rst = 1'b1;
    step(1'b0, 24'd0, 1'b0, 1'b0, acc, ov, ir, d, obs);
    rst = 1'b0;
    expq.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid);
    end
    p = {8'd200, 8'd60, 8'd190};
    step(1'b1, p, 1'b1, 1'b1, acc, ov, ir, d, obs);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 24'd0, 1'b0, 1'b1, acc, ov, ir, d, obs);
      if (d) begin lat = k; break; end
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL rstmid_latency got %0d want 3", lat);
    end
    e = (expq.size() > 0) ? expq.pop_front() : 25'h0;
    checks++;
    if (obs !== model(p, 1'b1) || obs !== e) begin
      errors++; $display("FAIL rstmid_pixel got %h want %h", obs, model(p, 1'b1));
    end
  endtask

  task automatic test_random_sweep();
    logic acc, ov, ir, d;
    logic [24:0] obs, e;
    logic [23:0] p;
    int n, bad;
    n = 0; bad = 0;
    for (int k = 0; k < 20000; k++) begin
      if (k < 8) p = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};  // every 0/255 corner first
      else       p = 24'($urandom);
      step((k < 8) || ($urandom_range(0, 3) != 0), p, 1'($urandom), 1'b1, acc, ov, ir, d, obs);
      if (d) begin
        n++;
        e = (expq.size() > 0) ? expq.pop_front() : 25'h0;
        checks++;
        if (obs !== e) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL sweep_pixel #%0d got %h want %h", n, obs, e);
        end
      end
    end
    for (int k = 0; k < 10 && expq.size() > 0; k++) begin
      step(1'b0, 24'd0, 1'b0, 1'b1, acc, ov, ir, d, obs);
      if (d) begin
        e = expq.pop_front();
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL sweep_tail got %h want %h", obs, e);
        end
      end
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL sweep_drain got %0d pending want 0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_throughput();
    test_backpressure();
    test_reset_mid_burst();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
